// File: rtl/isqrt_sum_n_fsm_if.sv
// Bus between isqrt_sum_n_fsm, its argument source and its isqrt units.
// slave is the summing block's view; master is the source/unit side.
interface isqrt_sum_n_fsm_if #(
    parameter int W       = 32,
    parameter int N_ARGS  = 3,
    parameter int N_ISQRT = 2
);
    logic                         arg_vld;
    logic                         arg_rdy;
    logic [N_ARGS*W-1:0]          args;
    logic                         res_vld;
    logic [W-1:0]                 res;
    logic [N_ISQRT-1:0]           isqrt_x_vld;
    logic [N_ISQRT*W-1:0]         isqrt_x;
    logic [N_ISQRT-1:0]           isqrt_y_vld;
    logic [(N_ISQRT*W/2)-1:0]     isqrt_y;

    modport slave (
        input  arg_vld, args, isqrt_y_vld, isqrt_y,
        output arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
    );

    modport master (
        output arg_vld, args, isqrt_y_vld, isqrt_y,
        input  arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
    );
endinterface

// File: rtl/isqrt_sum_n_fsm.sv
// Sums isqrt(arg[i]) over N_ARGS captured arguments, issuing them in batches
// of N_ISQRT to external isqrt units and waiting for the slowest used unit
// of each batch before moving on.
module isqrt_sum_n_fsm #(
    parameter int W       = 32,
    parameter int N_ARGS  = 3,
    parameter int N_ISQRT = 2
) (
    input  logic               clk,
    input  logic               rst,
    isqrt_sum_n_fsm_if.slave   bus
);
    localparam int B  = (N_ARGS + N_ISQRT - 1) / N_ISQRT;
    localparam int BW = (B > 1) ? $clog2(B) : 1;
    localparam int HW = W / 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [N_ARGS*W-1:0]    args_q, args_d;
    logic [BW-1:0]          batch_q, batch_d;
    logic [W-1:0]           acc_q, acc_d;
    logic [W-1:0]           res_q, res_d;
    logic [N_ISQRT-1:0]     done_q, done_d;
    logic                   res_vld_q, res_vld_d;
    logic                   arg_rdy_q, arg_rdy_d;

    logic [N_ISQRT-1:0]     used_s;
    logic [N_ISQRT*W-1:0]   operand_s;
    logic [N_ISQRT-1:0]     x_vld_s;
    logic [N_ISQRT*W-1:0]   x_s;
    logic [N_ISQRT-1:0]     ret_s;
    logic [W-1:0]           add_s;
    logic                   all_done_s;
    logic                   last_s;

    // Map the current batch onto units; operands are driven only in ISSUE, else zero.
    always_comb begin
        used_s    = '0;
        operand_s = '0;
        for (int i = 0; i < N_ARGS; i++) begin
            used_s[i % N_ISQRT] = used_s[i % N_ISQRT] | (int'(batch_q) == (i / N_ISQRT));
            operand_s[(i % N_ISQRT)*W +: W] = operand_s[(i % N_ISQRT)*W +: W] |
                ((int'(batch_q) == (i / N_ISQRT)) ? args_q[i*W +: W] : {W{1'b0}});
        end
        x_vld_s = used_s & {N_ISQRT{state_q == S_ISSUE}};
        x_s     = (state_q == S_ISSUE) ? operand_s : '0;
    end

    // Collect first-time returns of used units; several may land in one cycle.
    always_comb begin
        ret_s = '0;
        add_s = '0;
        for (int u = 0; u < N_ISQRT; u++) begin
            ret_s[u] = used_s[u] & bus.isqrt_y_vld[u] & ~done_q[u];
            add_s    = add_s + (ret_s[u] ? {{HW{1'b0}}, bus.isqrt_y[u*HW +: HW]} : {W{1'b0}});
        end
        all_done_s = &(done_q | ret_s | ~used_s);
        last_s     = (batch_q == BW'(B - 1));
    end

    // Next-state and datapath updates for capture, issue and wait.
    always_comb begin
        state_d   = state_q;
        args_d    = args_q;
        batch_d   = batch_q;
        acc_d     = acc_q;
        done_d    = done_q;
        res_d     = res_q;
        res_vld_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.arg_vld) begin
                    args_d  = bus.args;
                    acc_d   = '0;
                    batch_d = '0;
                    res_d   = '0;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                done_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                acc_d  = acc_q + add_s;
                done_d = done_q | ret_s;
                if (all_done_s) begin
                    if (last_s) begin
                        res_d     = acc_q + add_s;
                        res_vld_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        batch_d = batch_q + BW'(1);
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        arg_rdy_d = (state_d == S_IDLE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured arguments, accumulator, per-unit flags and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            args_q    <= '0;
            batch_q   <= '0;
            acc_q     <= '0;
            done_q    <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            arg_rdy_q <= 1'b1;
        end else begin
            args_q    <= args_d;
            batch_q   <= batch_d;
            acc_q     <= acc_d;
            done_q    <= done_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            arg_rdy_q <= arg_rdy_d;
        end
    end

    assign bus.arg_rdy     = arg_rdy_q;
    assign bus.res_vld     = res_vld_q;
    assign bus.res         = res_q;
    assign bus.isqrt_x_vld = x_vld_s;
    assign bus.isqrt_x     = x_s;
endmodule

// File: doc/isqrt_sum_n_fsm.md
# isqrt_sum_n_fsm

- Computes res = isqrt(arg[0]) + isqrt(arg[1]) + … + isqrt(arg[N_ARGS-1]) using N_ISQRT external isqrt units.
- The units are scheduled in batches by an FSM.
- It is the parametrised successor of the fixed three-argument, two-unit formula FSMs. It adds argument capture, a ready handshake and tolerance of unequal unit latencies.
- It sits between the argument source and the shared isqrt units in the sqrt-formula subsystem.

## Interface
Parameters:
- W, default 32: argument width; must be even. isqrt result width is W/2.
- N_ARGS, default 3: number of arguments summed; range 1 to 2^(W/2).
- N_ISQRT, default 2: number of isqrt units driven; 1 ≤ N_ISQRT ≤ N_ARGS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- arg_vld  in  1  argument strobe.
- arg_rdy  out  1  block is idle and able to accept arguments.
- args  in  N_ARGS*W  packed arguments; arg[i] = args[i*W +: W].
- res_vld  out  1  one-cycle result strobe.
- res  out  W  sum of isqrt results.
- isqrt_x_vld  out  N_ISQRT  per-unit request strobe.
- isqrt_x  out  N_ISQRT*W  per-unit operand; unit u uses [u*W +: W].
- isqrt_y_vld  in  N_ISQRT  per-unit result strobe.
- isqrt_y  in  N_ISQRT*W/2  per-unit result; unit u uses [u*W/2 +: W/2].

## Operation
- Batches: B = ceil(N_ARGS/N_ISQRT). Batch k sends arg[k*N_ISQRT+u] to unit u, for each index below N_ARGS. Units with no argument in the last batch stay idle.
- Argument capture: on arg_vld & arg_rdy, all args are registered, the accumulator is cleared and the batch index is set to 0. After capture, the input args are not sampled again.
- States:
  - IDLE: arg_rdy=1. On arg_vld, capture and go to ISSUE.
  - ISSUE: assert isqrt_x_vld for the used units of the current batch for exactly one cycle. Clear the per-unit done flags. Go to WAIT.
  - WAIT: for each used unit u with isqrt_y_vld[u]=1 and done[u]=0, add zero-extended isqrt_y[u] to the accumulator and set done[u]. Several units may return in the same cycle; all of them are added in that cycle.
  - WAIT exit: when every used unit is done (counting returns in the current cycle):
    - if this is the last batch, go to IDLE and pulse res_vld;
    - otherwise increment the batch index and go to ISSUE.
- Ignored strobes:
  - isqrt_y_vld in IDLE or ISSUE;
  - isqrt_y_vld on unused units;
  - a repeated strobe on a unit that is already done.
- Idle operand value: isqrt_x = 0 whenever the corresponding isqrt_x_vld = 0.
- Arithmetic: the accumulator is W bits and wraps modulo 2^W. It cannot overflow within the parameter limits above.
- res holds its value after res_vld until the next capture, which clears it to 0.
- arg_vld while arg_rdy=0 is dropped; no queueing.

## Timing
- Reset values: arg_rdy=1 (IDLE), res_vld=0, res=0, isqrt_x_vld=0, isqrt_x=0.
- Reset mid-operation: the next cycle is IDLE and the partial sum is discarded. Results from units still in flight are ignored while the FSM is in IDLE.
- Cycle numbering: capture is at edge 0; cycle 1 is the first ISSUE cycle.
- Fixed unit latency L ≥ 1: batch k issues in cycle 1 + k(L+1), and its results arrive L cycles later.
- res_vld is high in cycle B(L+1)+1. With defaults (B=2) and L=1, that is cycle 5.
- Unequal latencies: each batch waits for its slowest used unit.
- Back-to-back operation: arg_rdy is already 1 in the cycle res_vld is high, so a new argument set may be accepted in that cycle.
- Outputs: res_vld, res and arg_rdy are registered. isqrt_x_vld and isqrt_x are decoded from the state register only and are not combinational from any input.

## Test plan
- Defaults, L=1, args (4, 9, 16): res_vld pulses in cycle 5 with res=9. Unit 0 gets 4 then 16; unit 1 gets 9, and its x_vld stays 0 in batch 1.
- Unit 0 latency 1 and unit 1 latency 4, args (100, 2, 0): WAIT lasts until unit 1 returns. Result res=11.
- arg_vld held high for 10 cycles: exactly two operations run, the second captured in the res_vld cycle. Arguments presented while arg_rdy=0 never affect res.
- rst asserted in the first WAIT cycle, then args (1, 1, 1): late strobes are ignored, no res_vld appears before the new operation, and the result is res=3.
- N_ARGS=5, N_ISQRT=2, all args 0xFFFFFFFF: B=3 and res=327675 (5 × 65535). The last batch uses unit 0 only.
- Spurious isqrt_y_vld in IDLE, plus a duplicate strobe on a unit already done, with args (0, 0, 0): res=0.
